// File: rtl/d_flip_flop.sv
// Positive-edge D register with synchronous active-high reset.
// STAGES cascaded registers turn it into a short fixed-latency delay line.
module d_flip_flop #(
  parameter int unsigned     WIDTH       = 1,
  parameter logic [1023:0]   RESET_VALUE = '0,
  parameter int unsigned     STAGES      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  generate
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
      $error("d_flip_flop: WIDTH=%0d outside 1..1024", WIDTH);
    end
    if (STAGES < 1 || STAGES > 64) begin : g_bad_stages
      $error("d_flip_flop: STAGES=%0d outside 1..64", STAGES);
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_reg;
      logic [WIDTH-1:0] stage_next;

      // Stage 0 samples the input; later stages sample their predecessor.
      if (gi == 0) begin : g_first
        assign stage_next = d;
      end else begin : g_chain
        assign stage_next = g_stage[gi-1].stage_reg;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          stage_reg <= RST_VAL;
        end else begin
          stage_reg <= stage_next;
        end
      end
    end
  endgenerate

  assign q = g_stage[STAGES-1].stage_reg;

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: a default 1-bit instance and an 8-bit/A5/3-stage
// instance, compared each edge against a per-edge input-history model.
module tb_d_flip_flop;

  logic       clk = 1'b0;
  logic       rst1, rst8;
  logic       d1, q1;
  logic [7:0] d8, q8;

  int total = 0;
  int bad   = 0;

  // Every (rst, d) pair seen on a rising edge, oldest first.
  bit         r1_hist[$];
  logic [7:0] d1_hist[$];
  bit         r8_hist[$];
  logic [7:0] d8_hist[$];

  always #5 clk = ~clk;

  d_flip_flop dut1 (
    .clk(clk),
    .rst(rst1),
    .d  (d1),
    .q  (q1)
  );

  d_flip_flop #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5),
    .STAGES     (3)
  ) dut8 (
    .clk(clk),
    .rst(rst8),
    .d  (d8),
    .q  (q8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h want=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // q after the latest edge: a reset within the last `stages` edges leaves
  // the reset value at the output; otherwise q is d from `stages` edges ago.
  function automatic logic [7:0] model_q(input int stages, input logic [7:0] rv,
                                         input bit rh[$], input logic [7:0] dh[$]);
    int n;
    n = rh.size() - 1;
    for (int k = 0; k < stages; k++) begin
      if (n - k < 0) return rv;
      if (rh[n-k]) return rv;
    end
    return dh[n-stages+1];
  endfunction

  // One clock: drive at the falling edge (optionally wiggling d first to
  // prove q ignores activity between edges), record at the rising edge,
  // compare just after it.
  task automatic edge_step(input string tag, input bit r1v, input logic d1v,
                           input bit r8v, input logic [7:0] d8v, input bit wiggle);
    logic [7:0] hold1, hold8;
    @(negedge clk);
    if (wiggle) begin
      hold1 = {7'd0, q1};
      hold8 = q8;
      for (int i = 0; i < 3; i++) begin
        d1   = ~d1;
        d8   = d8 ^ 8'(($urandom() & 32'hFF) | 32'h1);
        rst1 = ~rst1;
        rst8 = ~rst8;
        #1;
        check({tag, "_hold1"}, {7'd0, q1}, hold1);
        check({tag, "_hold8"}, q8, hold8);
      end
    end
    rst1 = r1v;
    d1   = d1v;
    rst8 = r8v;
    d8   = d8v;
    @(posedge clk);
    r1_hist.push_back(r1v);
    d1_hist.push_back({7'd0, d1v});
    r8_hist.push_back(r8v);
    d8_hist.push_back(d8v);
    #1;
    check({tag, "_q1"}, {7'd0, q1}, model_q(1, 8'h00, r1_hist, d1_hist));
    check({tag, "_q8"}, q8, model_q(3, 8'hA5, r8_hist, d8_hist));
  endtask

  initial begin
    rst1 = 1'b0;
    rst8 = 1'b0;
    d1   = 1'b0;
    d8   = 8'h00;

    // Reset held for two edges with d high.
    edge_step("rst_a", 1, 1'b1, 1, 8'hFF, 0);
    check("rst_a_const1", {7'd0, q1}, 8'h00);
    check("rst_a_const8", q8, 8'hA5);
    edge_step("rst_b", 1, 1'b1, 1, 8'hFF, 0);
    check("rst_b_const1", {7'd0, q1}, 8'h00);

    // Data capture 1,0,1 and the 8-bit pipeline filling with 01,02,03...
    edge_step("cap0", 0, 1'b1, 0, 8'h01, 0);
    check("cap0_fill8", q8, 8'hA5);
    edge_step("cap1", 0, 1'b0, 0, 8'h02, 0);
    check("cap1_fill8", q8, 8'hA5);
    edge_step("cap2", 0, 1'b1, 0, 8'h03, 0);
    check("cap2_const1", {7'd0, q1}, 8'h01);
    check("cap2_const8", q8, 8'h01);
    edge_step("cap3", 0, 1'b1, 0, 8'h04, 0);
    check("cap3_const8", q8, 8'h02);

    // Mid-stream reset on both instances with d high.
    edge_step("mid_rst", 1, 1'b1, 1, 8'h05, 0);
    check("mid_rst_const1", {7'd0, q1}, 8'h00);
    check("mid_rst_const8", q8, 8'hA5);
    edge_step("mid_rel0", 0, 1'b0, 0, 8'h06, 0);
    edge_step("mid_rel1", 0, 1'b1, 0, 8'h07, 0);
    check("mid_rel1_const1", {7'd0, q1}, 8'h01);
    edge_step("mid_rel2", 0, 1'b0, 0, 8'h08, 0);
    check("mid_rel2_const8", q8, 8'h06);

    // Inputs toggling between edges must not disturb q.
    for (int i = 0; i < 4; i++)
      edge_step("hold", 0, 1'($urandom()), 0, 8'($urandom()), 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++)
      edge_step("rnd", ($urandom_range(0, 15) == 0), 1'($urandom()),
                ($urandom_range(0, 15) == 0), 8'($urandom()), (i % 25 == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
